// File: rtl/boid_pkg.sv
// Shared types and widths for the boid pixel writer: FSM states, the
// position-table entry, and the coordinate/colour widths.
package boid_pkg;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 8;
  localparam int ID_W    = 6;
  localparam int ADDR_W  = X_W + Y_W;
  localparam int CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ERASE,
    DRAW,
    UPDATE,
    CLEAR
  } state_t;

  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_entry_t;

  // Linear pixel-buffer address: row in the upper bits, column in the lower.
  function automatic logic [ADDR_W-1:0] pix_addr_of(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/boid_pos_table.sv
// Last drawn position of every boid slot. One shared address for read and
// write; the read is registered (one cycle of latency). Only the valid bits
// are reset, so the coordinate storage stays plain memory.
module boid_pos_table
  import boid_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ID_W-1:0]  addr,
  input  logic             we,
  input  pos_entry_t       wdata,
  output pos_entry_t       rdata
);

  logic [DEPTH-1:0] valid_q;
  logic [X_W-1:0]   x_mem [DEPTH];
  logic [Y_W-1:0]   y_mem [DEPTH];
  pos_entry_t       rdata_q;

  // Valid bits: cleared together on reset, otherwise written one at a time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[addr] <= wdata.valid;
    end
  end

  // Coordinate storage and the registered read port (old data on a collision).
  always_ff @(posedge clk) begin
    if (we) begin
      x_mem[addr] <= wdata.x;
      y_mem[addr] <= wdata.y;
    end
    rdata_q <= '{valid: valid_q[addr], x: x_mem[addr], y: y_mem[addr]};
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/boid_pixel_writer.sv
// Boid pixel writer: accepts position updates, erases the boid's previous
// pixel, draws the new one, and remembers where it was drawn. A clear request
// walks the table forgetting every stored position.
module boid_pixel_writer
  import boid_pkg::*;
#(
  parameter int                 MAX_BOIDS = 64,
  parameter int                 SCREEN_W  = 640,
  parameter int                 SCREEN_H  = 480,
  parameter logic [COLOR_W-1:0] BG_COLOR  = 8'h00
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic               boid_valid,
  output logic               boid_ready,
  input  logic [ID_W-1:0]    boid_id,
  input  logic [X_W-1:0]     boid_x,
  input  logic [Y_W-1:0]     boid_y,
  input  logic [COLOR_W-1:0] boid_color,
  input  logic               clear_all,
  output logic               pix_write,
  output logic [ADDR_W-1:0]  pix_addr,
  output logic [COLOR_W-1:0] pix_data,
  input  logic               pix_waitrequest,
  output logic               busy,
  output logic [CNT_W-1:0]   draw_count
);

  state_t             state_q;
  logic [ID_W-1:0]    id_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [COLOR_W-1:0] color_q;
  logic [ID_W-1:0]    clr_idx_q;
  logic               clipped_q;
  logic               drew_q;
  logic               pix_write_q;
  logic [ADDR_W-1:0]  pix_addr_q;
  logic [COLOR_W-1:0] pix_data_q;
  logic               busy_q;
  logic [CNT_W-1:0]   draw_count_q;

  logic [ID_W-1:0]    tbl_addr;
  logic               tbl_we;
  pos_entry_t         entry_d;
  pos_entry_t         old_entry;
  logic               xfer;
  logic               clip_now;
  logic               need_erase;

  // Ready only while idle and not pre-empted by a clear in the same cycle.
  assign boid_ready = (state_q == IDLE) && reset_n && !clear_all;
  assign xfer       = boid_valid && boid_ready;

  assign clip_now   = (int'(x_q) >= SCREEN_W) || (int'(y_q) >= SCREEN_H);
  assign need_erase = old_entry.valid && ((old_entry.x != x_q) || (old_entry.y != y_q));

  // Table port steering: look up the incoming id while idle so the entry is
  // ready in LOOKUP; write back in UPDATE; walk the indices in CLEAR.
  always_comb begin
    tbl_addr = id_q;
    tbl_we   = 1'b0;
    entry_d  = '0;
    unique case (state_q)
      IDLE: begin
        tbl_addr = boid_id;
      end
      UPDATE: begin
        tbl_we  = 1'b1;
        entry_d = '{valid: ~clipped_q, x: x_q, y: y_q};
      end
      CLEAR: begin
        tbl_addr = clr_idx_q;
        tbl_we   = 1'b1;
        entry_d  = '0;
      end
      default: begin
      end
    endcase
  end

  boid_pos_table #(
    .DEPTH(MAX_BOIDS)
  ) u_table (
    .clk    (CLOCK_50),
    .reset_n(reset_n),
    .addr   (tbl_addr),
    .we     (tbl_we),
    .wdata  (entry_d),
    .rdata  (old_entry)
  );

  // Capture the update payload on the accepting edge.
  always_ff @(posedge CLOCK_50) begin
    if (xfer) begin
      id_q    <= boid_id;
      x_q     <= boid_x;
      y_q     <= boid_y;
      color_q <= boid_color;
    end
  end

  // Main controller with registered pixel-bus, busy and counter outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pix_write_q  <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      busy_q       <= 1'b0;
      draw_count_q <= '0;
      clr_idx_q    <= '0;
      clipped_q    <= 1'b0;
      drew_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clear_all) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            busy_q    <= 1'b1;
          end else if (xfer) begin
            state_q <= LOOKUP;
            busy_q  <= 1'b1;
          end
        end

        LOOKUP: begin
          clipped_q <= clip_now;
          drew_q    <= 1'b0;
          if (need_erase) begin
            state_q     <= ERASE;
            pix_write_q <= 1'b1;
            pix_addr_q  <= pix_addr_of(old_entry.x, old_entry.y);
            pix_data_q  <= BG_COLOR;
          end else if (!clip_now) begin
            state_q     <= DRAW;
            pix_write_q <= 1'b1;
            pix_addr_q  <= pix_addr_of(x_q, y_q);
            pix_data_q  <= color_q;
          end else begin
            state_q <= UPDATE;
          end
        end

        ERASE: begin
          if (!pix_waitrequest) begin
            if (!clipped_q) begin
              state_q    <= DRAW;
              pix_addr_q <= pix_addr_of(x_q, y_q);
              pix_data_q <= color_q;
            end else begin
              state_q     <= UPDATE;
              pix_write_q <= 1'b0;
            end
          end
        end

        DRAW: begin
          if (!pix_waitrequest) begin
            state_q     <= UPDATE;
            pix_write_q <= 1'b0;
            drew_q      <= 1'b1;
          end
        end

        UPDATE: begin
          if (drew_q) begin
            draw_count_q <= draw_count_q + CNT_W'(1);
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        CLEAR: begin
          if (clr_idx_q == ID_W'(MAX_BOIDS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + ID_W'(1);
          end
        end

        default: begin
          state_q     <= IDLE;
          pix_write_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign pix_write  = pix_write_q;
  assign pix_addr   = pix_addr_q;
  assign pix_data   = pix_data_q;
  assign busy       = busy_q;
  assign draw_count = draw_count_q;

endmodule

// File: tb/tb_boid_pixel_writer.sv
// Bench for boid_pixel_writer: directed scenarios plus randomized updates
// checked against a per-slot position model.
module tb_boid_pixel_writer;

  localparam int SW = 640;
  localparam int SH = 480;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        boid_valid;
  logic        boid_ready;
  logic [5:0]  boid_id;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic [7:0]  boid_color;
  logic        clear_all;
  logic        pix_write;
  logic [18:0] pix_addr;
  logic [7:0]  pix_data;
  logic        pix_waitrequest;
  logic        busy;
  logic [15:0] draw_count;

  int vectors     = 0;
  int miscompares = 0;

  bit         mvalid [64];
  bit [9:0]   mx     [64];
  bit [8:0]   my     [64];
  bit [15:0]  mcount;

  always #5 CLOCK_50 = ~CLOCK_50;

  boid_pixel_writer dut (
    .CLOCK_50       (CLOCK_50),
    .reset_n        (reset_n),
    .boid_valid     (boid_valid),
    .boid_ready     (boid_ready),
    .boid_id        (boid_id),
    .boid_x         (boid_x),
    .boid_y         (boid_y),
    .boid_color     (boid_color),
    .clear_all      (clear_all),
    .pix_write      (pix_write),
    .pix_addr       (pix_addr),
    .pix_data       (pix_data),
    .pix_waitrequest(pix_waitrequest),
    .busy           (busy),
    .draw_count     (draw_count)
  );

  task automatic model_forget();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  // One position update: model predicts the pixel writes, bench drives the
  // handshake and waitrequest, then compares writes, latency and counter.
  task automatic do_update(input int id, input int x, input int y, input int color,
                           input int wait_mode, input bit noise, input string tag);
    logic [18:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic [18:0] got_addr[$];
    logic [7:0]  got_data[$];
    logic [18:0] pa;
    logic [7:0]  pd;
    int  waits = 0, first_cyc = -1, ready_cyc = -1, wait_left = 0, want_lat;
    bit  stalled = 0, clipped;

    clipped = (x >= SW) || (y >= SH);
    if (mvalid[id] && (int'(mx[id]) != x || int'(my[id]) != y)) begin
      exp_addr.push_back({my[id], mx[id]});
      exp_data.push_back(8'h00);
    end
    if (!clipped) begin
      exp_addr.push_back({9'(y), 10'(x)});
      exp_data.push_back(8'(color));
      mcount = mcount + 16'd1;
    end
    mvalid[id] = !clipped;
    mx[id] = 10'(x);
    my[id] = 9'(y);

    @(negedge CLOCK_50);
    vectors++;
    if (boid_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before: got %b want 1", tag, boid_ready);
    end
    boid_valid = 1'b1;
    boid_id    = 6'(id);
    boid_x     = 10'(x);
    boid_y     = 9'(y);
    boid_color = 8'(color);

    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge CLOCK_50);
      if (cyc == 1) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s busy_active: got %b want 1", tag, busy);
        end
        boid_valid = noise;
        clear_all  = noise;
        boid_id    = 6'($urandom_range(0, 63));
        boid_x     = 10'($urandom_range(0, 639));
        boid_y     = 9'($urandom_range(0, 479));
        boid_color = 8'($urandom_range(0, 255));
      end else begin
        boid_valid = 1'b0;
        clear_all  = 1'b0;
      end
      if (stalled) begin
        vectors++;
        if (pix_write !== 1'b1 || pix_addr !== pa || pix_data !== pd) begin
          miscompares++;
          $display("FAIL %s hold: got w=%b a=%h d=%h want w=1 a=%h d=%h",
                   tag, pix_write, pix_addr, pix_data, pa, pd);
        end
      end
      if (pix_write === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (!stalled) wait_left = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
        if (wait_left > 0) begin
          pix_waitrequest = 1'b1;
          wait_left--;
          waits++;
          stalled = 1'b1;
          pa = pix_addr;
          pd = pix_data;
        end else begin
          pix_waitrequest = 1'b0;
          stalled = 1'b0;
          got_addr.push_back(pix_addr);
          got_data.push_back(pix_data);
        end
      end else begin
        pix_waitrequest = 1'($urandom_range(0, 1));
        stalled = 1'b0;
      end
      if (boid_ready === 1'b1) begin
        ready_cyc = cyc;
        break;
      end
    end
    pix_waitrequest = 1'b0;
    boid_valid = 1'b0;
    clear_all  = 1'b0;

    want_lat = 3 + exp_addr.size() + waits;
    vectors++;
    if (ready_cyc != want_lat) begin
      miscompares++;
      $display("FAIL %s ready_latency: got %0d want %0d", tag, ready_cyc, want_lat);
    end
    vectors++;
    if (first_cyc != ((exp_addr.size() > 0) ? 2 : -1)) begin
      miscompares++;
      $display("FAIL %s first_write_cycle: got %0d want %0d", tag, first_cyc,
               (exp_addr.size() > 0) ? 2 : -1);
    end
    vectors++;
    if (got_addr.size() != exp_addr.size()) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d want %0d", tag, got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        vectors++;
        if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
          miscompares++;
          $display("FAIL %s write%0d: got a=%h d=%h want a=%h d=%h", tag, i,
                   got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    vectors++;
    if (draw_count !== mcount) begin
      miscompares++;
      $display("FAIL %s draw_count: got %h want %h", tag, draw_count, mcount);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_idle: got %b want 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    vectors++;
    if (pix_write !== 1'b0 || pix_addr !== 19'd0 || pix_data !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_pix: got w=%b a=%h d=%h want 0 0 0", pix_write, pix_addr, pix_data);
    end
    vectors++;
    if (busy !== 1'b0 || boid_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got busy=%b ready=%b want 0 0", busy, boid_ready);
    end
    vectors++;
    if (draw_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %h want 0000", draw_count);
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if (boid_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", boid_ready);
    end
    model_forget();
    mcount = 16'd0;
  endtask

  task automatic test_directed();
    do_update(3, 100, 50, 8'hE0, 0, 1'b0, "first_draw");
    do_update(3, 101, 50, 8'hE0, 0, 1'b0, "move");
    do_update(3, 101, 50, 8'hE0, 3, 1'b0, "same_pos_wait");
    do_update(7, 640, 10, 8'h1C, 0, 1'b0, "clipped_x");
    do_update(7, 5, 5, 8'h1C, 0, 1'b0, "after_clip");
    do_update(8, 20, 480, 8'h3F, 0, 1'b0, "clipped_y");
  endtask

  task automatic test_clear();
    int n = 0;
    bit wrote = 1'b0;
    @(negedge CLOCK_50);
    clear_all  = 1'b1;
    boid_valid = 1'b1;
    boid_id    = 6'd5;
    boid_x     = 10'd9;
    boid_y     = 9'd9;
    boid_color = 8'hAA;
    #1;
    vectors++;
    if (boid_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_priority_ready: got %b want 0", boid_ready);
    end
    @(negedge CLOCK_50);
    clear_all  = 1'b0;
    boid_valid = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      if (pix_write !== 1'b0) wrote = 1'b1;
      n++;
      @(negedge CLOCK_50);
    end
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL clear_busy_cycles: got %0d want 64", n);
    end
    vectors++;
    if (wrote) begin
      miscompares++;
      $display("FAIL clear_no_writes: got pixel write want none");
    end
    model_forget();
    do_update(3, 0, 0, 8'h55, 0, 1'b0, "post_clear");
    do_update(5, 9, 9, 8'hAA, 0, 1'b0, "post_clear_id5");
  endtask

  task automatic test_random();
    int id, x, y;
    for (int t = 0; t < 150; t++) begin
      id = int'($urandom_range(0, 7));
      if (mvalid[id] && $urandom_range(0, 3) == 0) begin
        x = int'(mx[id]);
        y = int'(my[id]);
      end else begin
        x = int'($urandom_range(0, 700));
        y = int'($urandom_range(0, 511));
      end
      do_update(id, x, y, int'($urandom_range(0, 255)), -1, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_abort();
    do_update(3, 300, 100, 8'h77, 0, 1'b0, "abort_setup");
    @(negedge CLOCK_50);
    boid_valid = 1'b1;
    boid_id    = 6'd3;
    boid_x     = 10'd301;
    boid_y     = 9'd100;
    boid_color = 8'h77;
    @(negedge CLOCK_50);
    boid_valid      = 1'b0;
    pix_waitrequest = 1'b1;
    @(negedge CLOCK_50);
    vectors++;
    if (pix_write !== 1'b1 || pix_addr !== {9'd100, 10'd300} || pix_data !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_erase: got w=%b a=%h d=%h want w=1 a=%h d=00",
               pix_write, pix_addr, pix_data, {9'd100, 10'd300});
    end
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    vectors++;
    if (pix_write !== 1'b0 || draw_count !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: got w=%b cnt=%h busy=%b want 0 0000 0",
               pix_write, draw_count, busy);
    end
    reset_n = 1'b1;
    pix_waitrequest = 1'b0;
    model_forget();
    mcount = 16'd0;
    do_update(3, 301, 100, 8'h77, 0, 1'b0, "after_abort");
  endtask

  task automatic test_wrap();
    @(negedge CLOCK_50);
    force dut.draw_count_q = 16'hFFFC;
    @(negedge CLOCK_50);
    release dut.draw_count_q;
    mcount = 16'hFFFC;
    for (int k = 0; k < 6; k++) begin
      do_update(9, 10 + k, 20, 8'hC3, 0, 1'b0, "wrap");
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    boid_valid      = 1'b0;
    boid_id         = '0;
    boid_x          = '0;
    boid_y          = '0;
    boid_color      = '0;
    clear_all       = 1'b0;
    pix_waitrequest = 1'b0;
    mcount          = 16'd0;
    test_reset();
    test_directed();
    test_clear();
    test_random();
    test_reset_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
